// File: rtl/led_pattern_shifter.sv
// led_pattern_shifter: prescaled multi-mode pattern shifter for LED banks.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   en    - step enable (freezes prescaler and pattern when low)
//   mode  - 0 rotate left, 1 rotate right, 2 bounce, 3 Johnson
//   load  - synchronous parallel load strobe (wins over a step)
//   din   - parallel load value
//   q     - current pattern
//   dir   - bounce direction (0 toward MSB, 1 toward LSB), 0 outside bounce
//   tick  - one-cycle pulse after every step
//   wrap  - one-cycle pulse after a step that lands on INIT
module led_pattern_shifter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1),
  parameter int unsigned      DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [1:0] MODE_ROTL   = 2'd0;
  localparam logic [1:0] MODE_ROTR   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  logic [WIDTH-1:0] q_r = INIT;
  logic             dir_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;
  logic             wrap_r;

  logic [WIDTH-1:0] q_nxt;
  logic             dir_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tick_nxt;
  logic             wrap_nxt;
  logic             step_c;

  // Next-state: load > step > hold; dir only survives while in bounce mode.
  always_comb begin
    q_nxt    = q_r;
    dir_nxt  = (mode == MODE_BOUNCE) ? dir_r : 1'b0;
    cnt_nxt  = cnt_r;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    step_c   = en && (cnt_r == CNT_MAX);

    if (load) begin
      q_nxt   = din;
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (step_c) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      // An all-zero pattern would stick forever in the shifting modes.
      if ((mode != 2'd3) && (q_r == '0)) begin
        q_nxt   = INIT;
        dir_nxt = 1'b0;
      end else begin
        case (mode)
          MODE_ROTL:   q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          MODE_ROTR:   q_nxt = {q_r[0], q_r[WIDTH-1:1]};
          MODE_BOUNCE: begin
            // Turn around on reaching an end so the end bit is not repeated.
            if (!dir_r) begin
              if (q_r[WIDTH-1]) begin
                dir_nxt = 1'b1;
                q_nxt   = q_r >> 1;
              end else begin
                q_nxt   = q_r << 1;
              end
            end else begin
              if (q_r[0]) begin
                dir_nxt = 1'b0;
                q_nxt   = q_r << 1;
              end else begin
                q_nxt   = q_r >> 1;
              end
            end
          end
          default:     q_nxt = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        endcase
      end
      wrap_nxt = (q_nxt == INIT);
    end else if (en) begin
      cnt_nxt = cnt_r + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= INIT;
      dir_r  <= 1'b0;
      cnt_r  <= '0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      dir_r  <= dir_nxt;
      cnt_r  <= cnt_nxt;
      tick_r <= tick_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign q    = q_r;
  assign dir  = dir_r;
  assign tick = tick_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Self-checking bench: two shifter instances (4-bit DIV=1, 8-bit DIV=3)
// compared every cycle against an integer reference model, plus directed
// pattern sequences with literal expected values.
module tb_led_pattern_shifter;

  localparam int unsigned WA = 4;
  localparam int unsigned WB = 8;
  localparam int unsigned DA = 1;
  localparam int unsigned DB = 3;
  localparam logic [3:0]  IA = 4'h1;
  localparam logic [7:0]  IB = 8'h11;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, load_a, en_b, load_b;
  logic [1:0] mode_a, mode_b;
  logic [3:0] din_a, q_a;
  logic [7:0] din_b, q_b;
  logic       dir_a, tick_a, wrap_a, dir_b, tick_b, wrap_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int unsigned mq[2], mdir[2], mcnt[2], mtk[2], mwr[2];

  led_pattern_shifter #(.WIDTH(WA), .INIT(IA), .DIV(DA)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .load(load_a), .din(din_a),
    .q(q_a), .dir(dir_a), .tick(tick_a), .wrap(wrap_a)
  );

  led_pattern_shifter #(.WIDTH(WB), .INIT(IB), .DIV(DB)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .load(load_b), .din(din_b),
    .q(q_b), .dir(dir_b), .tick(tick_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq[0] = 32'(IA);
    mq[1] = 32'(IB);
    for (int i = 0; i < 2; i++) begin
      mdir[i] = 0; mcnt[i] = 0; mtk[i] = 0; mwr[i] = 0;
    end
  endtask

  // Pattern behaviour written as plain integer arithmetic on the value.
  task automatic model_upd(input int i, input int unsigned w, input int unsigned init,
                           input int unsigned div, input int unsigned en,
                           input int unsigned mode, input int unsigned load,
                           input int unsigned din);
    int unsigned m, s, top, nq;
    m   = (32'd1 << w) - 1;
    s   = mq[i];
    top = (s >> (w - 1)) & 1;
    nq  = s;
    mtk[i] = 0;
    mwr[i] = 0;
    if (load != 0) begin
      mq[i] = din; mcnt[i] = 0; mdir[i] = 0;
    end else if (en != 0 && mcnt[i] == div - 1) begin
      mcnt[i] = 0;
      mtk[i]  = 1;
      if (mode != 3 && s == 0) begin
        nq = init; mdir[i] = 0;
      end else begin
        case (mode)
          0: nq = ((s * 2) & m) | top;
          1: nq = (s / 2) | ((s % 2) << (w - 1));
          2: begin
            if (mdir[i] == 0) begin
              if (top == 1) begin mdir[i] = 1; nq = s / 2; end
              else nq = (s * 2) & m;
            end else begin
              if (s % 2 == 1) begin mdir[i] = 0; nq = (s * 2) & m; end
              else nq = s / 2;
            end
          end
          default: nq = ((s * 2) & m) | (1 - top);
        endcase
      end
      mq[i]  = nq;
      mwr[i] = (nq == init) ? 1 : 0;
    end else if (en != 0) begin
      mcnt[i]++;
    end
    if (mode != 2) mdir[i] = 0;
  endtask

  task automatic check_all();
    chk("a_q",    32'(q_a),    mq[0]);
    chk("a_dir",  32'(dir_a),  mdir[0]);
    chk("a_tick", 32'(tick_a), mtk[0]);
    chk("a_wrap", 32'(wrap_a), mwr[0]);
    chk("b_q",    32'(q_b),    mq[1]);
    chk("b_dir",  32'(dir_b),  mdir[1]);
    chk("b_tick", 32'(tick_b), mtk[1]);
    chk("b_wrap", 32'(wrap_b), mwr[1]);
  endtask

  // One clock: model follows the inputs sampled at the edge, compare 1ns later.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst) model_reset();
      else begin
        model_upd(0, WA, 32'(IA), DA, 32'(en_a), 32'(mode_a), 32'(load_a), 32'(din_a));
        model_upd(1, WB, 32'(IB), DB, 32'(en_b), 32'(mode_b), 32'(load_b), 32'(din_b));
      end
      #1;
      check_all();
    end
  endtask

  task automatic load_a_val(input logic [3:0] v, input logic [1:0] md);
    load_a = 1'b1; din_a = v; mode_a = md;
    cyc(1);
    load_a = 1'b0;
  endtask

  initial begin
    logic [3:0] rl [6];
    logic [3:0] bq [7];
    logic       bd [7];
    logic [3:0] jq [8];
    logic [7:0] frz;
    rl = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    bq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    bd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    jq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    rst = 1'b1;
    en_a = 1'b0; load_a = 1'b0; mode_a = 2'd0; din_a = '0;
    en_b = 1'b0; load_b = 1'b0; mode_b = 2'd1; din_b = '0;
    model_reset();
    cyc(2);
    chk("reset_q_a", 32'(q_a), 32'h1);
    chk("reset_q_b", 32'(q_b), 32'h11);
    rst = 1'b0;

    // Rotate left on A; B runs rotate right in the background.
    en_a = 1'b1; en_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("rotl_seq", 32'(q_a), 32'(rl[i]));
      chk("rotl_tick", 32'(tick_a), 32'h1);
      chk("rotl_wrap", 32'(wrap_a), (i == 3) ? 32'h1 : 32'h0);
    end

    // Bounce from a single bit.
    load_a_val(4'h1, 2'd2);
    chk("load_no_tick", 32'(tick_a), 32'h0);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk("bounce_q", 32'(q_a), 32'(bq[i]));
      chk("bounce_dir", 32'(dir_a), 32'(bd[i]));
      chk("bounce_wrap", 32'(wrap_a), (i == 5) ? 32'h1 : 32'h0);
    end

    // Johnson from all-zero, full period of 2*WIDTH.
    load_a_val(4'h0, 2'd3);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("johnson_q", 32'(q_a), 32'(jq[i]));
    end

    // Zero recovery in rotate mode.
    load_a_val(4'h0, 2'd0);
    cyc(1);
    chk("zero_rec_q", 32'(q_a), 32'h1);
    chk("zero_rec_wrap", 32'(wrap_a), 32'h1);

    // Leave bounce while heading toward LSB.
    load_a_val(4'h1, 2'd2);
    cyc(4);
    chk("pre_switch_dir", 32'(dir_a), 32'h1);
    mode_a = 2'd0;
    cyc(1);
    chk("switch_dir", 32'(dir_a), 32'h0);
    chk("switch_q", 32'(q_a), 32'h8);

    // B: freeze mid-count, then load on a step cycle.
    mode_b = 2'd1;
    cyc(1);
    en_b = 1'b0;
    frz = q_b;
    cyc(5);
    chk("freeze_q", 32'(q_b), 32'(frz));
    en_b = 1'b1;
    for (int k = 0; k < 4 && mcnt[1] != DB - 1; k++) cyc(1);
    chk("b_at_step", mcnt[1], DB - 1);
    load_b = 1'b1; din_b = 8'h81;
    cyc(1);
    load_b = 1'b0;
    chk("b_load_q", 32'(q_b), 32'h81);
    chk("b_load_tick", 32'(tick_b), 32'h0);
    cyc(2);
    chk("b_hold_q", 32'(q_b), 32'h81);
    cyc(1);
    chk("b_step_q", 32'(q_b), 32'hC0);
    chk("b_step_tick", 32'(tick_b), 32'h1);

    // Randomised traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      en_a   = ($urandom_range(0, 9) < 8);
      en_b   = ($urandom_range(0, 9) < 8);
      load_a = ($urandom_range(0, 19) == 0);
      load_b = ($urandom_range(0, 19) == 0);
      din_a  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      din_b  = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
      if ($urandom_range(0, 15) == 0) mode_a = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mode_b = 2'($urandom);
      cyc(1);
    end
    load_a = 1'b0; load_b = 1'b0;

    // Asynchronous reset mid-bounce with dir=1.
    en_a = 1'b1;
    load_a_val(4'h1, 2'd2);
    cyc(4);
    chk("pre_rst_dir", 32'(dir_a), 32'h1);
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    cyc(1);
    rst = 1'b0;
    cyc(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
